sdram_port_arbiter: RTL

- Shares the single-port, slot-based SDRAM controller between NPORTS independent requesters, e.g. video fetch, CPU and audio/DMA.
- Holds one transaction in flight at a time.
- Selects among ports with an optional high-priority port plus round-robin among the rest.
- Registers the granted address, data and byte enables toward the controller, and returns read data and a completion pulse to the granted port.

---
 rtl/sdram_port_arbiter_pkg.sv | 20 ++
 rtl/sdram_port_arbiter_if.sv | 42 ++++
 rtl/sdram_port_arbiter_rr_picker.sv | 34 +++
 rtl/sdram_port_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared types and default widths for the SDRAM port arbiter.
// Revision : 1.0
// ============================================================================
package sdram_arb_pkg;

    localparam int unsigned AW_DEFAULT = 24;
    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned MEM_BEW    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter_if
// Brief    : Requester-side and controller-side buses of the SDRAM arbiter.
// Revision : 1.0
// ============================================================================
interface sdram_port_arbiter_if #(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 16
);
    import sdram_arb_pkg::*;

    logic [NPORTS-1:0]         p_req;
    logic [NPORTS-1:0]         p_wr;
    logic [NPORTS*AW-1:0]      p_addr;
    logic [NPORTS*DW-1:0]      p_wdata;
    logic [NPORTS*MEM_BEW-1:0] p_be;
    logic [NPORTS-1:0]         p_ack;
    logic [DW-1:0]             p_rdata;

    logic                      mem_req;
    logic                      mem_wr;
    logic [AW-1:0]             mem_addr;
    logic [DW-1:0]             mem_wdata;
    logic [MEM_BEW-1:0]        mem_be;
    logic                      mem_ack;
    logic [DW-1:0]             mem_rdata;

    // master: the arbiter itself; slave: requesters plus controller around it
    modport master (
        input  p_req, p_wr, p_addr, p_wdata, p_be, mem_ack, mem_rdata,
        output p_ack, p_rdata, mem_req, mem_wr, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output p_req, p_wr, p_addr, p_wdata, p_be, mem_ack, mem_rdata,
        input  p_ack, p_rdata, mem_req, mem_wr, mem_addr, mem_wdata, mem_be
    );

endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick starting at ptr, wrapping at NPORTS.
// Revision : 1.0
// ============================================================================
module rr_picker #(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned IW     = 2
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] grant,
    output logic [IW-1:0]     grant_idx
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NPORTS; k++) begin
            // explicit modulo keeps the wrap correct for non-power-of-two NPORTS
            idx = IW'((32'(ptr) + 32'(k)) % NPORTS);
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : One-in-flight arbiter sharing the SDRAM controller between ports.
// Revision : 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NPORTS     = 3,
    parameter int unsigned AW         = AW_DEFAULT,
    parameter int unsigned DW         = DW_DEFAULT,
    parameter bit          HIPRI_EN   = 1'b1,
    parameter int unsigned HIPRI_PORT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_port_arbiter_if.master bus,
    output logic                 busy
);

    localparam int unsigned       IW         = $clog2(NPORTS);
    localparam logic [NPORTS-1:0] HIPRI_MASK = HIPRI_EN ? (NPORTS'(1) << HIPRI_PORT) : '0;
    localparam logic [IW-1:0]     HIPRI_IDX  = IW'(HIPRI_PORT);
    localparam logic [IW-1:0]     LAST_IDX   = IW'(NPORTS - 1);

    arb_state_t         state;
    arb_state_t         state_next;
    logic               load;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      sel_idx;
    logic [NPORTS-1:0]  pick_grant;
    logic [NPORTS-1:0]  scan_req;
    logic               hipri_hit;
    logic               any_req;

    logic               sel_wr;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [MEM_BEW-1:0] sel_be;

    // priority port is removed from the scan so it never consumes an RR slot
    assign scan_req  = bus.p_req & ~HIPRI_MASK;
    assign hipri_hit = |(bus.p_req & HIPRI_MASK);
    assign any_req   = hipri_hit | (|pick_grant);

    rr_picker #(
        .NPORTS    (NPORTS),
        .IW        (IW)
    ) u_rr_picker (
        .req       (scan_req),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    always_comb begin
        sel_idx   = hipri_hit ? HIPRI_IDX : pick_idx;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (sel_idx == IW'(k)) begin
                sel_wr    = bus.p_wr[k];
                sel_addr  = bus.p_addr[k*AW +: AW];
                sel_wdata = bus.p_wdata[k*DW +: DW];
                sel_be    = bus.p_be[k*MEM_BEW +: MEM_BEW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load       = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            win_idx       <= '0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.p_rdata   <= '0;
        end else begin
            if (load) begin
                win_idx       <= sel_idx;
                bus.mem_wr    <= sel_wr;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                bus.mem_be    <= sel_be;
            end
            if (state == WAIT && bus.mem_ack && !bus.mem_wr) begin
                bus.p_rdata <= bus.mem_rdata;
            end
            if (state == DONE && !(HIPRI_EN && win_idx == HIPRI_IDX)) begin
                rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
            end
        end
    end

    assign bus.mem_req = (state == WAIT);
    assign busy        = (state != IDLE);

    always_comb begin
        bus.p_ack = '0;
        for (int k = 0; k < NPORTS; k++) begin
            bus.p_ack[k] = (state == DONE) && (win_idx == IW'(k));
        end
    end

endmodule
`default_nettype wire
